weight_loader: RTL and testbench

WEIGHT_LOADER -- requirements
Module: weight_loader

---
 rtl/vTPU_pkg.sv | 17 +
 rtl/weight_extend.sv | 17 +
 rtl/weight_loader.sv | 148 ++++++++++++++
 tb/tb_weight_loader.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/vTPU_pkg.sv
// vTPU_pkg: shared types for the vTPU weight path.
//   BYTE_TYPE          - raw 8-bit weight as delivered upstream.
//   EXTENDED_BYTE_TYPE - 9-bit weight as consumed by the PE array.
//   wl_state_t         - weight_loader FSM states.
package vTPU_pkg;

  typedef logic [7:0] BYTE_TYPE;
  typedef logic [8:0] EXTENDED_BYTE_TYPE;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WAIT_SWAP,
    SWAP
  } wl_state_t;

endpackage

// File: rtl/weight_extend.sv
// weight_extend: widens one weight byte to EXTENDED_BYTE_TYPE.
//   in_byte  - raw weight byte
//   sign_ext - 1: replicate bit 7 into the extra bit, 0: zero-extend
//   out_byte - extended weight
import vTPU_pkg::*;

module weight_extend (
  input  BYTE_TYPE          in_byte,
  input  logic              sign_ext,
  output EXTENDED_BYTE_TYPE out_byte
);

  always_comb begin
    out_byte = {sign_ext & in_byte[7], in_byte};
  end

endmodule

// File: rtl/weight_loader.sv
// weight_loader: streams one MATRIX_WIDTH x MATRIX_WIDTH weight tile, row by
// row, into the PE preweight chain and then requests a preweight->weight swap.
//   clk, reset      - clock, synchronous active-high reset
//   start           - one-cycle tile request (ignored unless idle)
//   wt_signed       - tile signedness, latched with start
//   wt_valid/ready  - row-beat handshake, wt_data is one row
//   swap_allow      - array permits the swap this cycle
//   weight_output   - extended row driven to the column weight inputs
//   preload_weight  - preweight chain shift enable (one per accepted row)
//   load_weight     - one-cycle swap pulse
//   busy, done      - not-idle flag, one-cycle tile-complete pulse
// Build option: define WEIGHT_LOADER_SIGNED_EN to honour wt_signed
// (sign-extension); otherwise rows are always zero-extended.
import vTPU_pkg::*;

module weight_loader #(
  parameter int MATRIX_WIDTH = 8
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic                                 wt_signed,
  input  logic                                 wt_valid,
  output logic                                 wt_ready,
  input  BYTE_TYPE          [MATRIX_WIDTH-1:0] wt_data,
  input  logic                                 swap_allow,
  output EXTENDED_BYTE_TYPE [MATRIX_WIDTH-1:0] weight_output,
  output logic                                 preload_weight,
  output logic                                 load_weight,
  output logic                                 busy,
  output logic                                 done
);

  localparam int CNT_W = $clog2(MATRIX_WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(MATRIX_WIDTH - 1);

`ifdef WEIGHT_LOADER_SIGNED_EN
  localparam bit SIGN_EN = 1'b1;
`else
  localparam bit SIGN_EN = 1'b0;
`endif

  wl_state_t                             state_q, state_d;
  logic [CNT_W-1:0]                      row_cnt_q, row_cnt_d;
  logic                                  signed_q, signed_d;
  logic                                  wt_ready_q, wt_ready_d;
  logic                                  preload_q, preload_d;
  logic                                  load_q, load_d;
  logic                                  busy_q, busy_d;
  logic                                  done_q, done_d;
  EXTENDED_BYTE_TYPE [MATRIX_WIDTH-1:0]  wout_q, wout_d;

  EXTENDED_BYTE_TYPE [MATRIX_WIDTH-1:0]  ext_row;
  logic                                  sign_ext;
  logic                                  accept;

  assign sign_ext = signed_q & SIGN_EN;
  // wt_ready_q is high exactly while in FETCH, so it doubles as the state qualifier.
  assign accept   = wt_valid & wt_ready_q;

  for (genvar i = 0; i < MATRIX_WIDTH; i++) begin : g_ext
    weight_extend u_ext (
      .in_byte  (wt_data[i]),
      .sign_ext (sign_ext),
      .out_byte (ext_row[i])
    );
  end

  always_comb begin
    state_d    = state_q;
    row_cnt_d  = row_cnt_q;
    signed_d   = signed_q;
    wt_ready_d = wt_ready_q;
    busy_d     = busy_q;
    load_d     = 1'b0;
    done_d     = 1'b0;
    // Each accepted beat appears on the chain exactly one cycle later.
    preload_d  = accept;
    wout_d     = accept ? ext_row : wout_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = FETCH;
          row_cnt_d  = '0;
          signed_d   = wt_signed;
          wt_ready_d = 1'b1;
          busy_d     = 1'b1;
        end
      end
      FETCH: begin
        if (accept) begin
          row_cnt_d = row_cnt_q + 1'b1;
          if (row_cnt_q == LAST_ROW) begin
            state_d    = WAIT_SWAP;
            wt_ready_d = 1'b0;
          end
        end
      end
      WAIT_SWAP: begin
        // Entering WAIT_SWAP coincides with the final preload, so the swap
        // pulse can never overlap a shift.
        if (swap_allow) begin
          state_d = SWAP;
          load_d  = 1'b1;
          done_d  = 1'b1;
        end
      end
      SWAP: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      row_cnt_q  <= '0;
      signed_q   <= 1'b0;
      wt_ready_q <= 1'b0;
      preload_q  <= 1'b0;
      load_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wout_q     <= '0;
    end else begin
      state_q    <= state_d;
      row_cnt_q  <= row_cnt_d;
      signed_q   <= signed_d;
      wt_ready_q <= wt_ready_d;
      preload_q  <= preload_d;
      load_q     <= load_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      wout_q     <= wout_d;
    end
  end

  assign wt_ready       = wt_ready_q;
  assign preload_weight = preload_q;
  assign load_weight    = load_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign weight_output  = wout_q;

endmodule

// File: tb/tb_weight_loader.sv
// tb_weight_loader: self-checking bench for weight_loader (MATRIX_WIDTH=4).
// Honours WEIGHT_LOADER_SIGNED_EN for the expected extension.
import vTPU_pkg::*;

module tb_weight_loader;

  localparam int MW = 4;

  logic clk = 1'b0;
  logic reset, start, wt_signed, wt_valid, swap_allow;
  logic wt_ready, preload_weight, load_weight, busy, done;
  BYTE_TYPE          [MW-1:0] wt_data;
  EXTENDED_BYTE_TYPE [MW-1:0] weight_output;

  int checks = 0;
  int errors = 0;

  logic [35:0] exp_wout;

  always #5 clk = ~clk;

  weight_loader #(.MATRIX_WIDTH(MW)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .wt_signed      (wt_signed),
    .wt_valid       (wt_valid),
    .wt_ready       (wt_ready),
    .wt_data        (wt_data),
    .swap_allow     (swap_allow),
    .weight_output  (weight_output),
    .preload_weight (preload_weight),
    .load_weight    (load_weight),
    .busy           (busy),
    .done           (done)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [8:0] ext_model(input logic [7:0] b, input logic sgn);
    logic en;
`ifdef WEIGHT_LOADER_SIGNED_EN
    en = 1'b1;
`else
    en = 1'b0;
`endif
    if (en && sgn && b >= 8'd128) return 9'(b) + 9'd256;
    return 9'(b);
  endfunction

  function automatic logic [35:0] ext_row(input logic [31:0] r, input logic sgn);
    logic [35:0] o;
    for (int b = 0; b < MW; b++) o[b*9 +: 9] = ext_model(r[b*8 +: 8], sgn);
    return o;
  endfunction

  task automatic check_all(input string tag, input logic rdy, input logic pre,
                           input logic ld, input logic bsy);
    chk({tag, " wt_ready"}, 64'(wt_ready), 64'(rdy));
    chk({tag, " preload_weight"}, 64'(preload_weight), 64'(pre));
    chk({tag, " load_weight"}, 64'(load_weight), 64'(ld));
    chk({tag, " done"}, 64'(done), 64'(ld));
    chk({tag, " busy"}, 64'(busy), 64'(bsy));
    chk({tag, " weight_output"}, 64'(weight_output), 64'(exp_wout));
  endtask

  // Runs one 40-cycle tile window starting with start in cycle 0. Expected
  // behaviour is derived from the beat schedule: the first MW valid cycles
  // are the accepts, each row shows one cycle later, the swap lands one cycle
  // after the first swap_allow following the last accept.
  task automatic run_tile(input logic [39:0] vmask, input logic [39:0] smask,
                          input logic [39:0] stmask, input logic sgn,
                          input logic [127:0] rows, output int obs_ld, output int obs_pre);
    int acc[MW];
    int n, last, s, ld, k, pj;
    n = 0;
    for (int c = 1; c < 40; c++)
      if (vmask[c] && n < MW) begin acc[n] = c; n++; end
    obs_ld = -1;
    obs_pre = 0;
    if (n < MW) begin
      errors++;
      $display("FAIL tile_setup: got %0d beats expected %0d", n, MW);
      return;
    end
    last = acc[MW-1];
    s = 39;
    for (int c = 39; c > last; c--) if (smask[c]) s = c;
    ld = s + 1;
    for (int c = 0; c < 40; c++) begin
      k = 0;
      for (int j = 0; j < MW; j++) if (acc[j] < c) k++;
      start      = (c == 0) || (stmask[c] && c <= last);
      wt_signed  = (c == 0) ? sgn : 1'($urandom_range(1));
      wt_valid   = (c >= 1) && vmask[c];
      swap_allow = smask[c];
      for (int b = 0; b < MW; b++)
        wt_data[b] = (wt_valid && c <= last) ? rows[k*32 + b*8 +: 8] : 8'($urandom);
      @(negedge clk);
      pj = -1;
      for (int j = 0; j < MW; j++) if (acc[j] + 1 == c) pj = j;
      if (pj >= 0) exp_wout = ext_row(rows[pj*32 +: 32], sgn);
      check_all($sformatf("c%0d", c), (c >= 1 && c <= last), (pj >= 0),
                (c == ld), (c >= 1 && c <= ld));
      if (load_weight && obs_ld < 0) obs_ld = c;
      if (preload_weight) obs_pre++;
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    logic [39:0]  vmask;
    logic [39:0]  smask;
    logic [39:0]  stmask;
    logic         sgn;
    logic [127:0] rows;
    int           exp_ld;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int obs_ld, obs_pre;
    logic [127:0] rr;
    logic [39:0]  vm, sm, stm;
    logic [8:0]   sx;

    tbl[0] = '{40'hFF_FFFF_FFFE, 40'hFF_FFFF_FFFF, 40'h0, 1'b0,
               128'h04040404_03030303_02020202_01010101, 6};
    tbl[1] = '{40'hAA_AAAA_AAAA, 40'hFF_FFFF_FFFF, 40'h0, 1'b0,
               128'h44332211_8877_6655_CCBBAA99_00FFEEDD, 9};
    tbl[2] = '{40'hFF_FFFF_FFFE, 40'hFF_FFFF_8000, 40'h0, 1'b1,
               128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0, 16};
    tbl[3] = '{40'hFF_FFFF_FFFE, 40'hFF_FFFF_FFFF, 40'h0, 1'b1,
               {4{32'h80808080}}, 6};
    tbl[4] = '{40'hAA_AAAA_AAAA, 40'hFF_FFFF_FFFF, 40'h0000_000C, 1'b0,
               128'h11111111_22222222_33333333_44444444, 9};

    reset = 1'b1; start = 1'b0; wt_signed = 1'b0; wt_valid = 1'b0;
    swap_allow = 1'b0; wt_data = '0; exp_wout = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_all("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 5; i++) begin
      run_tile(tbl[i].vmask, tbl[i].smask, tbl[i].stmask, tbl[i].sgn, tbl[i].rows,
               obs_ld, obs_pre);
      chk($sformatf("vec%0d load_cycle", i), 64'(obs_ld), 64'(tbl[i].exp_ld));
      chk($sformatf("vec%0d preload_count", i), 64'(obs_pre), 64'(MW));
      if (i == 3) begin
`ifdef WEIGHT_LOADER_SIGNED_EN
        sx = 9'h180;
`else
        sx = 9'h080;
`endif
        chk("ext_0x80", 64'(weight_output), 64'({4{sx}}));
      end
    end

    // Reset two beats into a tile, then a fresh tile must need all four beats.
    rr = 128'hDEADBEEF_CAFEF00D_5A5A5A5A_A5A5A5A5;
    start = 1'b1; wt_valid = 1'b0; wt_signed = 1'b0;
    @(negedge clk);
    check_all("rst c0", 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    start = 1'b0; wt_valid = 1'b1; wt_data = rr[31:0];
    @(negedge clk);
    check_all("rst c1", 1'b1, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    wt_data = rr[63:32];
    @(negedge clk);
    exp_wout = ext_row(rr[31:0], 1'b0);
    check_all("rst c2", 1'b1, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #1;
    wt_data = rr[95:64]; reset = 1'b1;
    @(negedge clk);
    exp_wout = ext_row(rr[63:32], 1'b0);
    check_all("rst c3", 1'b1, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #1;
    exp_wout = '0;
    for (int c = 4; c < 6; c++) begin
      wt_data = rr[127:96]; start = 1'b1; swap_allow = 1'b1;
      @(negedge clk);
      check_all($sformatf("rst c%0d", c), 1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
    end
    reset = 1'b0; start = 1'b0; wt_valid = 1'b0; swap_allow = 1'b0;
    @(negedge clk);
    check_all("rst c6", 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    run_tile(40'hFF_FFFF_FFFE, 40'hFF_FFFF_FFFF, 40'h0, 1'b0,
             128'h0A0B0C0D_1A1B1C1D_2A2B2C2D_3A3B3C3D, obs_ld, obs_pre);
    chk("post_reset load_cycle", 64'(obs_ld), 64'd6);
    chk("post_reset preload_count", 64'(obs_pre), 64'(MW));

    // Randomised tiles: gappy valid, late swap, spurious starts, random data.
    for (int t = 0; t < 20; t++) begin
      vm  = {8'($urandom), 32'($urandom)};
      vm[0] = 1'b0;
      vm[28:25] = 4'hF;
      sm  = {8'($urandom), 32'($urandom)} & {8'($urandom), 32'($urandom)};
      sm[37] = 1'b1;
      stm = {8'($urandom), 32'($urandom)} & {8'($urandom), 32'($urandom)};
      rr  = {$urandom, $urandom, $urandom, $urandom};
      run_tile(vm, sm, stm, 1'($urandom_range(1)), rr, obs_ld, obs_pre);
      chk($sformatf("rand%0d preload_count", t), 64'(obs_pre), 64'(MW));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
